// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator frequency measurement sequencer: clears the shared counter, gates
// one oscillator for a programmable window, lets the count settle, then captures it.
module ro_measure_ctrl #(
    parameter int CNT_W  = 8,
    parameter int WIN_W  = 16,
    parameter int NUM_RO = 4,
    parameter int SEL_W  = 2,
    parameter int SETTLE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              scan,
    input  logic [SEL_W-1:0]  ro_sel_in,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [CNT_W-1:0]  cnt_in,
    output logic              cnt_clr_n,
    output logic [NUM_RO-1:0] ro_en,
    output logic              busy,
    output logic [CNT_W-1:0]  result,
    output logic [SEL_W-1:0]  result_sel,
    output logic              result_valid,
    output logic              done,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_GATE    = 3'd2,
        S_SETTLE  = 3'd3,
        S_CAPTURE = 3'd4
    } state_e;

    // Phase counter holds "cycles remaining minus one" in the current timed state.
    localparam logic [WIN_W-1:0]  CLEAR_LAST  = WIN_W'(1);
    localparam logic [WIN_W-1:0]  SETTLE_LAST = WIN_W'(SETTLE - 1);
    localparam logic [WIN_W-1:0]  WIN_ONE     = WIN_W'(1);
    localparam logic [SEL_W-1:0]  LAST_IDX    = SEL_W'(NUM_RO - 1);
    localparam logic [SEL_W-1:0]  IDX_ONE     = SEL_W'(1);
    localparam logic [NUM_RO-1:0] EN_ONE      = NUM_RO'(1);

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic               scan_q, scan_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [WIN_W-1:0]   phase_q, phase_d;
    logic               cnt_clr_n_q, cnt_clr_n_d;
    logic [NUM_RO-1:0]  ro_en_q, ro_en_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic [SEL_W-1:0]   result_sel_q, result_sel_d;
    logic               result_valid_q, result_valid_d;
    logic               done_q, done_d;

    always_comb begin
        state_d        = state_q;
        win_d          = win_q;
        scan_d         = scan_q;
        idx_d          = idx_q;
        phase_d        = phase_q;
        result_d       = result_q;
        result_sel_d   = result_sel_q;
        result_valid_d = 1'b0;
        done_d         = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        win_d   = (win_len == '0) ? WIN_ONE : win_len;
                        scan_d  = scan;
                        idx_d   = scan ? '0 : ro_sel_in;
                        phase_d = CLEAR_LAST;
                        state_d = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (phase_q == '0) begin
                        phase_d = win_q - WIN_ONE;
                        state_d = S_GATE;
                    end else begin
                        phase_d = phase_q - WIN_ONE;
                    end
                end
                S_GATE: begin
                    if (phase_q == '0) begin
                        phase_d = SETTLE_LAST;
                        state_d = S_SETTLE;
                    end else begin
                        phase_d = phase_q - WIN_ONE;
                    end
                end
                S_SETTLE: begin
                    if (phase_q == '0) begin
                        state_d = S_CAPTURE;
                    end else begin
                        phase_d = phase_q - WIN_ONE;
                    end
                end
                S_CAPTURE: begin
                    result_d       = cnt_in;
                    result_sel_d   = idx_q;
                    result_valid_d = 1'b1;
                    if (scan_q && (idx_q < LAST_IDX)) begin
                        idx_d   = idx_q + IDX_ONE;
                        phase_d = CLEAR_LAST;
                        state_d = S_CLEAR;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register in step with it.
        cnt_clr_n_d = (state_d != S_CLEAR);
        busy_d      = (state_d != S_IDLE);
        ro_en_d     = (state_d == S_GATE) ? (EN_ONE << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            win_q          <= '0;
            scan_q         <= 1'b0;
            idx_q          <= '0;
            phase_q        <= '0;
            cnt_clr_n_q    <= 1'b0;
            ro_en_q        <= '0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_sel_q   <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_q          <= win_d;
            scan_q         <= scan_d;
            idx_q          <= idx_d;
            phase_q        <= phase_d;
            cnt_clr_n_q    <= cnt_clr_n_d;
            ro_en_q        <= ro_en_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_sel_q   <= result_sel_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
        end
    end

    assign cnt_clr_n    = cnt_clr_n_q;
    assign ro_en        = ro_en_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_sel   = result_sel_q;
    assign result_valid = result_valid_q;
    assign done         = done_q;
    assign dbg_state    = state_q;

endmodule
